// File: rtl/dbuf_pkg.sv
// Shared types for the double-buffered SRAM frame-store controller.
package dbuf_pkg;

    // Width of the per-access strobe hold counter (WAIT_CYCLES up to 15)
    localparam int unsigned WAIT_CNT_W   = 4;
    // Width of the Blitter starvation counter (optional guard only)
    localparam int unsigned STARVE_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ARMED,
        F_WAIT_BLIT,
        F_WAIT_VS
    } flip_state_t;

    typedef enum logic {
        REQ_VGA,
        REQ_BLIT
    } req_id_t;

endpackage

// File: rtl/dbuf_sram_ctrl_flip_fsm.sv
// Flip handshake between NIOS and Blitter, Vsync edge detection and the
// Front_Sel register. The swap itself is only allowed while the arbiter idles;
// a Vsync edge arriving mid-access is remembered until then.
module dbuf_flip_fsm
    import dbuf_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Arb_Idle,
    input  logic Nios_Flip,
    input  logic Blit_Busy,
    input  logic Vsync,
    output logic Swap_Now,
    output logic Front_Sel,
    output logic Flip_Pending,
    output logic Flip_Done
);

    flip_state_t state;
    flip_state_t state_next;
    logic        vsync_q;
    logic        vs_seen;
    logic        vs_edge;
    logic        swap;

    assign vs_edge  = Vsync & ~vsync_q;
    assign Swap_Now = swap;

    // Flip state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= F_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flip next-state logic and swap decision
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            F_IDLE: begin
                if (Nios_Flip) state_next = F_ARMED;
            end
            F_ARMED: begin
                if (!Nios_Flip) state_next = F_WAIT_BLIT;
            end
            F_WAIT_BLIT: begin
                if (!Blit_Busy) state_next = F_WAIT_VS;
            end
            F_WAIT_VS: begin
                if ((vs_edge || vs_seen) && Arb_Idle) begin
                    swap       = 1'b1;
                    state_next = F_IDLE;
                end
            end
            default: state_next = F_IDLE;
        endcase
    end

    // Vsync history and the latched edge for swaps deferred by a busy arbiter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vsync_q <= 1'b0;
            vs_seen <= 1'b0;
        end else begin
            vsync_q <= Vsync;
            vs_seen <= (state == F_WAIT_VS) && !swap && (vs_seen || vs_edge);
        end
    end

    // Registered flip outputs; Flip_Pending follows the state being entered
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Front_Sel    <= 1'b0;
            Flip_Pending <= 1'b0;
            Flip_Done    <= 1'b0;
        end else begin
            Front_Sel    <= Front_Sel ^ swap;
            Flip_Pending <= (state_next != F_IDLE);
            Flip_Done    <= swap;
        end
    end

endmodule

// File: rtl/dbuf_sram_ctrl.sv
// Double-buffered frame-store controller: arbitrates the single SRAM between
// VGA scan-out (front buffer) and the Blitter (back buffer), and swaps the
// buffers at vertical sync via dbuf_flip_fsm.
// Optional: define DBUF_STARVE_GUARD_EN to force a Blitter grant after
// MAX_STARVE consecutive losses to VGA.
module dbuf_sram_ctrl
    import dbuf_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MAX_STARVE  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Nios_Flip,
    input  logic              Blit_Busy,
    input  logic              Vsync,
    input  logic              Vga_Req,
    input  logic [ADDR_W-1:0] Vga_Addr,
    output logic              Vga_Ack,
    output logic [DATA_W-1:0] Vga_Rdata,
    input  logic              Blit_Req,
    input  logic              Blit_We,
    input  logic [ADDR_W-1:0] Blit_Addr,
    input  logic [DATA_W-1:0] Blit_Wdata,
    output logic              Blit_Ack,
    output logic [DATA_W-1:0] Blit_Rdata,
    output logic [ADDR_W:0]   Sram_Addr,
    output logic [DATA_W-1:0] Sram_Dq_Out,
    output logic              Sram_Dq_Oe,
    input  logic [DATA_W-1:0] Sram_Dq_In,
    output logic              Sram_We_N,
    output logic              Sram_Oe_N,
    output logic              Front_Sel,
    output logic              Flip_Pending,
    output logic              Flip_Done
);

    arb_state_t              arb_state;
    arb_state_t              arb_next;
    req_id_t                 req_id;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    grant_vga;
    logic                    grant_blit;
    logic                    grant_write;
    logic                    last_access;
    logic                    arb_idle;
    logic                    swap_now;
    logic                    front_now;

    assign arb_idle    = (arb_state == IDLE);
    // A grant in the swap cycle must already see the post-swap front buffer
    assign front_now   = Front_Sel ^ swap_now;
    assign grant_write = grant_blit & Blit_We;

`ifdef DBUF_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    force_blit;

    assign force_blit = (starve_cnt >= STARVE_CNT_W'(MAX_STARVE));

    // Count consecutive Blitter losses to VGA; any Blitter grant clears it
    always_ff @(posedge Clk) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (grant_blit) begin
            starve_cnt <= '0;
        end else if (grant_vga && Blit_Req) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_max_starve;
    assign unused_max_starve = (MAX_STARVE != 0);
`endif

    // Arbiter state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            arb_state <= IDLE;
        end else begin
            arb_state <= arb_next;
        end
    end

    // Arbiter next-state and grant decisions
    always_comb begin
        arb_next    = arb_state;
        grant_vga   = 1'b0;
        grant_blit  = 1'b0;
        last_access = 1'b0;
        case (arb_state)
            IDLE: begin
`ifdef DBUF_STARVE_GUARD_EN
                if (Blit_Req && (force_blit || !Vga_Req)) begin
                    grant_blit = 1'b1;
                end else if (Vga_Req) begin
                    grant_vga = 1'b1;
                end
`else
                if (Vga_Req) begin
                    grant_vga = 1'b1;
                end else if (Blit_Req) begin
                    grant_blit = 1'b1;
                end
`endif
                if (grant_vga || grant_blit) arb_next = ACCESS;
            end
            ACCESS: begin
                if (wait_cnt == WAIT_CNT_W'(WAIT_CYCLES - 1)) begin
                    last_access = 1'b1;
                    arb_next    = DONE;
                end
            end
            DONE: arb_next = IDLE;
            default: arb_next = IDLE;
        endcase
    end

    // SRAM pin registers, access latch, read capture and Ack pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            req_id      <= REQ_VGA;
            wait_cnt    <= '0;
            Sram_Addr   <= '0;
            Sram_Dq_Out <= '0;
            Sram_Dq_Oe  <= 1'b0;
            Sram_We_N   <= 1'b1;
            Sram_Oe_N   <= 1'b1;
            Vga_Ack     <= 1'b0;
            Vga_Rdata   <= '0;
            Blit_Ack    <= 1'b0;
            Blit_Rdata  <= '0;
        end else begin
            Vga_Ack  <= 1'b0;
            Blit_Ack <= 1'b0;
            if (grant_vga || grant_blit) begin
                req_id     <= grant_blit ? REQ_BLIT : REQ_VGA;
                Sram_Addr  <= grant_blit ? {~front_now, Blit_Addr} : {front_now, Vga_Addr};
                Sram_We_N  <= ~grant_write;
                Sram_Oe_N  <= grant_write;
                Sram_Dq_Oe <= grant_write;
                wait_cnt   <= '0;
                if (grant_write) Sram_Dq_Out <= Blit_Wdata;
            end else if (arb_state == ACCESS) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (last_access) begin
                    Sram_We_N  <= 1'b1;
                    Sram_Oe_N  <= 1'b1;
                    Sram_Dq_Oe <= 1'b0;
                    if (req_id == REQ_VGA) begin
                        Vga_Ack   <= 1'b1;
                        Vga_Rdata <= Sram_Dq_In;
                    end else begin
                        Blit_Ack <= 1'b1;
                        if (Sram_We_N) Blit_Rdata <= Sram_Dq_In;
                    end
                end
            end
        end
    end

    dbuf_flip_fsm u_flip (
        .Clk          (Clk),
        .Reset        (Reset),
        .Arb_Idle     (arb_idle),
        .Nios_Flip    (Nios_Flip),
        .Blit_Busy    (Blit_Busy),
        .Vsync        (Vsync),
        .Swap_Now     (swap_now),
        .Front_Sel    (Front_Sel),
        .Flip_Pending (Flip_Pending),
        .Flip_Done    (Flip_Done)
    );

endmodule

// File: tb/tb_dbuf_sram_ctrl.sv
// Directed testbench for dbuf_sram_ctrl (WAIT_CYCLES=2, MAX_STARVE=4).
module tb_dbuf_sram_ctrl;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Nios_Flip, Blit_Busy, Vsync;
    logic          Vga_Req;
    logic [AW-1:0] Vga_Addr;
    logic          Vga_Ack;
    logic [DW-1:0] Vga_Rdata;
    logic          Blit_Req, Blit_We;
    logic [AW-1:0] Blit_Addr;
    logic [DW-1:0] Blit_Wdata;
    logic          Blit_Ack;
    logic [DW-1:0] Blit_Rdata;
    logic [AW:0]   Sram_Addr;
    logic [DW-1:0] Sram_Dq_Out;
    logic          Sram_Dq_Oe;
    logic [DW-1:0] Sram_Dq_In;
    logic          Sram_We_N, Sram_Oe_N;
    logic          Front_Sel, Flip_Pending, Flip_Done;

    int errors = 0;
    int checks = 0;

    dbuf_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2), .MAX_STARVE(4)) dut (
        .Clk(Clk), .Reset(Reset), .Nios_Flip(Nios_Flip), .Blit_Busy(Blit_Busy), .Vsync(Vsync),
        .Vga_Req(Vga_Req), .Vga_Addr(Vga_Addr), .Vga_Ack(Vga_Ack), .Vga_Rdata(Vga_Rdata),
        .Blit_Req(Blit_Req), .Blit_We(Blit_We), .Blit_Addr(Blit_Addr), .Blit_Wdata(Blit_Wdata),
        .Blit_Ack(Blit_Ack), .Blit_Rdata(Blit_Rdata), .Sram_Addr(Sram_Addr),
        .Sram_Dq_Out(Sram_Dq_Out), .Sram_Dq_Oe(Sram_Dq_Oe), .Sram_Dq_In(Sram_Dq_In),
        .Sram_We_N(Sram_We_N), .Sram_Oe_N(Sram_Oe_N), .Front_Sel(Front_Sel),
        .Flip_Pending(Flip_Pending), .Flip_Done(Flip_Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Nios_Flip = 0; Blit_Busy = 0; Vsync = 0;
        Vga_Req = 0; Vga_Addr = '0; Blit_Req = 0; Blit_We = 0; Blit_Addr = '0;
        Blit_Wdata = '0; Sram_Dq_In = '0;
        tick(); tick();
        checks++; if ({Front_Sel, Flip_Pending, Flip_Done} !== 3'b000) begin errors++;
            $display("FAIL reset_flip: got %b want 000", {Front_Sel, Flip_Pending, Flip_Done}); end
        checks++; if ({Vga_Ack, Blit_Ack} !== 2'b00) begin errors++;
            $display("FAIL reset_ack: got %b want 00", {Vga_Ack, Blit_Ack}); end
        checks++; if ({Vga_Rdata, Blit_Rdata} !== 32'h0) begin errors++;
            $display("FAIL reset_rdata: got %h want 0", {Vga_Rdata, Blit_Rdata}); end
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe} !== 3'b110) begin errors++;
            $display("FAIL reset_strobes: got %b want 110", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe}); end
        checks++; if ({Sram_Addr, Sram_Dq_Out} !== 35'h0) begin errors++;
            $display("FAIL reset_addr_dq: got %h/%h want 0/0", Sram_Addr, Sram_Dq_Out); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_vga_read();
        Sram_Dq_In = 16'hBEEF; Vga_Addr = 18'h00010; Vga_Req = 1'b1;
        tick();
        checks++; if (Sram_Addr !== 19'h00010) begin errors++;
            $display("FAIL vga_addr: got %h want 00010", Sram_Addr); end
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack} !== 4'b1000) begin errors++;
            $display("FAIL vga_cyc1: got %b want 1000", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack}); end
        tick();
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack} !== 4'b1000) begin errors++;
            $display("FAIL vga_cyc2: got %b want 1000", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack}); end
        tick();
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack} !== 4'b1101) begin errors++;
            $display("FAIL vga_ack: got %b want 1101", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack}); end
        checks++; if (Vga_Rdata !== 16'hBEEF) begin errors++;
            $display("FAIL vga_rdata: got %h want BEEF", Vga_Rdata); end
        Vga_Req = 1'b0;
        tick();
        checks++; if (Vga_Ack !== 1'b0) begin errors++;
            $display("FAIL vga_ack_pulse: got %b want 0", Vga_Ack); end
    endtask

    task automatic test_blit_write();
        Sram_Dq_In = 16'h0F0F; Blit_Addr = 18'h00005; Blit_Wdata = 16'h1234; Blit_We = 1'b1; Blit_Req = 1'b1;
        tick();
        checks++; if (Sram_Addr !== 19'h40005) begin errors++;
            $display("FAIL blit_addr: got %h want 40005", Sram_Addr); end
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe} !== 3'b011 || Sram_Dq_Out !== 16'h1234) begin errors++;
            $display("FAIL blit_wr_cyc1: got %b/%h want 011/1234", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe}, Sram_Dq_Out); end
        tick();
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Blit_Ack} !== 4'b0110) begin errors++;
            $display("FAIL blit_wr_cyc2: got %b want 0110", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Blit_Ack}); end
        tick();
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Blit_Ack} !== 4'b1101) begin errors++;
            $display("FAIL blit_wr_ack: got %b want 1101", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Blit_Ack}); end
        Blit_Req = 1'b0;
        tick();
        checks++; if (Blit_Ack !== 1'b0 || Blit_Rdata !== 16'h0) begin errors++;
            $display("FAIL blit_wr_after: got ack=%b rdata=%h want 0/0000", Blit_Ack, Blit_Rdata); end
    endtask

    task automatic test_back_to_back();
        int vga_cyc = -1;
        int blit_cyc = -1;
        logic [AW:0]   blit_addr_seen = '0;
        logic [DW-1:0] vga_data = '0;
        logic [DW-1:0] blit_data = '0;
        Sram_Dq_In = 16'hC0DE;
        Vga_Addr = 18'h00123; Vga_Req = 1'b1;
        Blit_Addr = 18'h00ABC; Blit_We = 1'b0; Blit_Req = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (cyc == 5) blit_addr_seen = Sram_Addr;
            if (Vga_Ack) begin vga_cyc = cyc; vga_data = Vga_Rdata; Vga_Req = 1'b0; Sram_Dq_In = 16'h5A5A; end
            if (Blit_Ack) begin blit_cyc = cyc; blit_data = Blit_Rdata; Blit_Req = 1'b0; break; end
        end
        Vga_Req = 1'b0; Blit_Req = 1'b0;
        checks++; if (vga_cyc !== 3) begin errors++;
            $display("FAIL b2b_vga_latency: got %0d want 3", vga_cyc); end
        checks++; if (blit_cyc !== 7) begin errors++;
            $display("FAIL b2b_blit_latency: got %0d want 7", blit_cyc); end
        checks++; if (vga_data !== 16'hC0DE) begin errors++;
            $display("FAIL b2b_vga_rdata: got %h want C0DE", vga_data); end
        checks++; if (blit_data !== 16'h5A5A) begin errors++;
            $display("FAIL b2b_blit_rdata: got %h want 5A5A", blit_data); end
        checks++; if (blit_addr_seen !== 19'h40ABC) begin errors++;
            $display("FAIL b2b_blit_addr: got %h want 40ABC", blit_addr_seen); end
        tick();
    endtask

    task automatic test_flip();
        Blit_Busy = 1'b1; Nios_Flip = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (Flip_Pending !== 1'b1) begin errors++;
                $display("FAIL flip_armed_pending: cycle %0d got %b want 1", i, Flip_Pending); end
        end
        Nios_Flip = 1'b0;
        tick();
        Vsync = 1'b1; tick(); Vsync = 1'b0; tick();
        checks++; if ({Flip_Pending, Front_Sel, Flip_Done} !== 3'b100) begin errors++;
            $display("FAIL flip_early_vsync: got %b want 100", {Flip_Pending, Front_Sel, Flip_Done}); end
        Blit_Busy = 1'b0;
        tick();
        checks++; if ({Flip_Pending, Front_Sel} !== 2'b10) begin errors++;
            $display("FAIL flip_wait_vs: got %b want 10", {Flip_Pending, Front_Sel}); end
        Vsync = 1'b1;
        tick();
        checks++; if ({Flip_Pending, Front_Sel, Flip_Done} !== 3'b011) begin errors++;
            $display("FAIL flip_swap: got %b want 011", {Flip_Pending, Front_Sel, Flip_Done}); end
        Vsync = 1'b0;
        tick();
        checks++; if ({Front_Sel, Flip_Done} !== 2'b10) begin errors++;
            $display("FAIL flip_done_pulse: got %b want 10", {Front_Sel, Flip_Done}); end
    endtask

    task automatic test_deferred_swap();
        Nios_Flip = 1'b1; tick(); Nios_Flip = 1'b0; tick(); tick();
        Blit_Addr = 18'h00007; Blit_Wdata = 16'hA55A; Blit_We = 1'b1; Blit_Req = 1'b1;
        tick();
        checks++; if (Sram_Addr !== 19'h00007) begin errors++;
            $display("FAIL defer_grant_addr: got %h want 00007", Sram_Addr); end
        Vsync = 1'b1;
        tick();
        checks++; if ({Front_Sel, Flip_Pending, Sram_We_N, Sram_Addr} !== {3'b110, 19'h00007}) begin errors++;
            $display("FAIL defer_mid_access: got sel/pend/we_n=%b addr=%h want 110 00007",
                     {Front_Sel, Flip_Pending, Sram_We_N}, Sram_Addr); end
        tick();
        checks++; if ({Blit_Ack, Front_Sel, Flip_Done} !== 3'b110) begin errors++;
            $display("FAIL defer_done: got %b want 110", {Blit_Ack, Front_Sel, Flip_Done}); end
        Blit_Req = 1'b0;
        tick();
        checks++; if ({Front_Sel, Flip_Pending} !== 2'b11) begin errors++;
            $display("FAIL defer_idle_presw: got %b want 11", {Front_Sel, Flip_Pending}); end
        Blit_Addr = 18'h00009; Blit_We = 1'b0; Blit_Req = 1'b1;
        tick();
        checks++; if ({Front_Sel, Flip_Done, Flip_Pending} !== 3'b010) begin errors++;
            $display("FAIL defer_swap: got %b want 010", {Front_Sel, Flip_Done, Flip_Pending}); end
        checks++; if (Sram_Addr !== 19'h40009) begin errors++;
            $display("FAIL defer_swap_grant_addr: got %h want 40009", Sram_Addr); end
        Vsync = 1'b0;
        for (int i = 0; i < 10 && !Blit_Ack; i++) tick();
        checks++; if (Blit_Ack !== 1'b1) begin errors++;
            $display("FAIL defer_read_ack: got %b want 1", Blit_Ack); end
        Blit_Req = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        int vga_n = 0;
        int wins_before = -1;
        Vga_Addr = 18'h00002; Vga_Req = 1'b1;
        Blit_Addr = 18'h00003; Blit_We = 1'b0; Blit_Req = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (Vga_Ack) vga_n++;
            if (Blit_Ack) begin wins_before = vga_n; Blit_Req = 1'b0; break; end
            if (vga_n == 6) break;
        end
        Vga_Req = 1'b0;
`ifdef DBUF_STARVE_GUARD_EN
        checks++; if (wins_before !== 4) begin errors++;
            $display("FAIL starve_forced_grant: got %0d vga wins want 4", wins_before); end
`else
        checks++; if (wins_before !== -1 || vga_n !== 6) begin errors++;
            $display("FAIL strict_priority: got blit_after=%0d vga=%0d want -1/6", wins_before, vga_n); end
        for (int i = 0; i < 12 && !Blit_Ack; i++) tick();
        checks++; if (Blit_Ack !== 1'b1) begin errors++;
            $display("FAIL strict_blit_served: got %b want 1", Blit_Ack); end
        Blit_Req = 1'b0;
`endif
        tick();
    endtask

    task automatic test_reset_abort();
        Vga_Addr = 18'h00044; Vga_Req = 1'b1;
        tick();
        checks++; if (Sram_Oe_N !== 1'b0) begin errors++;
            $display("FAIL abort_started: got oe_n=%b want 0", Sram_Oe_N); end
        Reset = 1'b1; Vga_Req = 1'b0;
        tick();
        checks++; if ({Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack, Front_Sel} !== 5'b11000) begin errors++;
            $display("FAIL abort_reset: got %b want 11000", {Sram_We_N, Sram_Oe_N, Sram_Dq_Oe, Vga_Ack, Front_Sel}); end
        Reset = 1'b0;
        tick(); tick(); tick();
        checks++; if ({Vga_Ack, Sram_Oe_N} !== 2'b01) begin errors++;
            $display("FAIL abort_no_ack: got %b want 01", {Vga_Ack, Sram_Oe_N}); end
    endtask

    initial begin
        test_reset();
        test_vga_read();
        test_blit_write();
        test_back_to_back();
        test_flip();
        test_deferred_swap();
        test_starve();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbuf_sram_ctrl.md
Name: dbuf_sram_ctrl

Overview:
- Double-buffered frame-store controller in front of the single off-chip SRAM.
- Arbitrates word accesses between the VGA scan-out reader (front buffer) and the Blitter (back buffer).
- Sequences the NIOS/Blitter flip handshake and swaps front/back buffers only at vertical sync.
- Sits between the NIOS flip register, the Blitter, the VGA controller and the SRAM pins.

Parameters:
- ADDR_W, 18, per-buffer word address width; the SRAM address is ADDR_W+1 bits with the MSB as buffer select.
- DATA_W, 16, SRAM word width.
- WAIT_CYCLES, 2, cycles SRAM strobes are held per access; legal range 1..15.
- MAX_STARVE, 4, consecutive Blitter losses before forced grant; used only with the optional feature.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- Nios_Flip  in  1  level flip request from NIOS; software holds it high until Flip_Pending is seen
- Blit_Busy  in  1  Blitter is still drawing the back buffer
- Vsync  in  1  active-high vertical sync from the VGA controller
- Vga_Req  in  1  VGA read request; held with Vga_Addr until Vga_Ack
- Vga_Addr  in  ADDR_W  VGA word address
- Vga_Ack  out  1  one-cycle pulse; Vga_Rdata is valid in the same cycle
- Vga_Rdata  out  DATA_W  read data
- Blit_Req  in  1  Blitter request; held until Blit_Ack
- Blit_We  in  1  1 = write, 0 = read
- Blit_Addr  in  ADDR_W  Blitter word address
- Blit_Wdata  in  DATA_W  Blitter write data
- Blit_Ack  out  1  one-cycle pulse; Blit_Rdata is valid for reads
- Blit_Rdata  out  DATA_W  read data
- Sram_Addr  out  ADDR_W+1  {buffer bit, word address}
- Sram_Dq_Out  out  DATA_W  write data
- Sram_Dq_Oe  out  1  tri-state enable for Dq, high during writes
- Sram_Dq_In  in  DATA_W  read data from the pins
- Sram_We_N  out  1  active-low write strobe
- Sram_Oe_N  out  1  active-low output enable
- Front_Sel  out  1  buffer currently scanned out
- Flip_Pending  out  1  flip accepted, swap not yet done
- Flip_Done  out  1  one-cycle pulse at the swap

Behaviour:
- Reset values:
  - Front_Sel=0, Flip_Pending=0, Flip_Done=0.
  - Vga_Ack=0, Blit_Ack=0, both Rdata outputs = 0.
  - Sram_We_N=1, Sram_Oe_N=1, Sram_Dq_Oe=0, Sram_Addr=0, Sram_Dq_Out=0.
  - Both FSMs go to IDLE.
- Reset wins over every other input in any state; an in-flight access is abandoned with no Ack, and strobes deassert on the next edge.
- All outputs are registered.
- Arbiter FSM states: IDLE, ACCESS, DONE.
  - IDLE: if Vga_Req is high, grant VGA. Else if Blit_Req is high, grant Blitter. Else stay in IDLE.
  - On a grant: latch the requester, the address, the write data and the buffer bit (VGA uses Front_Sel, Blitter uses ~Front_Sel). Drive the strobes from the next cycle.
  - ACCESS: hold the strobes for exactly WAIT_CYCLES cycles using a 4-bit counter. Reads assert Oe_N=0. Writes assert We_N=0 with Dq_Oe=1.
  - On the last ACCESS cycle, capture Sram_Dq_In.
  - DONE: all strobes inactive. Pulse the granted Ack with its Rdata. Return to IDLE.
- Latency: a request first seen in IDLE at cycle N gets its Ack at cycle N+WAIT_CYCLES+1. Back-to-back accesses take WAIT_CYCLES+2 cycles each.
- Requesters drop or renew Req no earlier than the cycle after Ack. Req is not sampled in ACCESS or DONE.
- Simultaneous Vga_Req and Blit_Req in IDLE: VGA wins (strict priority).
- Flip FSM states: F_IDLE, F_ARMED, F_WAIT_BLIT, F_WAIT_VS.
  - F_IDLE: if Nios_Flip=1, go to F_ARMED.
  - F_ARMED: stay while Nios_Flip=1; on Nios_Flip=0, go to F_WAIT_BLIT.
  - F_WAIT_BLIT: when Blit_Busy=0, go to F_WAIT_VS.
  - F_WAIT_VS: wait for a Vsync rising edge, detected with a registered Vsync copy.
- Flip_Pending=1 in F_ARMED, F_WAIT_BLIT and F_WAIT_VS.
- Swap rules:
  - The swap toggles Front_Sel and pulses Flip_Done for one cycle, then the flip FSM returns to F_IDLE.
  - The swap executes only when the arbiter is in IDLE. If a Vsync edge arrives mid-access, the edge is remembered and the swap happens in the first arbiter IDLE cycle.
  - If the arbiter grants in the same IDLE cycle as the swap, that grant uses the new Front_Sel.
  - A Vsync edge seen in F_IDLE, F_ARMED or F_WAIT_BLIT is ignored and does not arm a later swap.
  - Nios_Flip re-asserted during F_WAIT_BLIT or F_WAIT_VS is ignored until F_IDLE.

Optional Feature:
- Macro: DBUF_STARVE_GUARD_EN.
- Defined:
  - A 3-bit counter increments each time the Blitter is requesting in IDLE but loses to VGA.
  - When the count reaches MAX_STARVE, the next IDLE with Blit_Req high grants the Blitter even if Vga_Req is high, and the counter clears.
  - The counter also clears on any Blitter grant.
- Undefined: strict VGA priority; no counter logic.

Decomposition:
- Package dbuf_pkg:
  - arb_state_t and flip_state_t enums.
  - Requester-id enum (REQ_VGA, REQ_BLIT).
  - Localparam for the wait-counter width.
- Sub-module dbuf_flip_fsm: the flip handshake, Vsync edge detect and Front_Sel register. Its inputs are Arb_Idle, Nios_Flip, Blit_Busy and Vsync.
- The top level holds the arbiter and the SRAM pin registers.

Test Plan:
- Reset, then Vga_Req with Vga_Addr=0x00010 and Sram_Dq_In=0xBEEF (WAIT_CYCLES=2) -> Sram_Addr=0x00010, Oe_N low for 2 cycles, Vga_Ack at N+3 with Vga_Rdata=0xBEEF.
- Blit write with Addr=0x00005, Wdata=0x1234, Front_Sel=0 -> Sram_Addr=0x40005, We_N low for 2 cycles, Dq_Oe=1, Dq_Out=0x1234, Blit_Ack at N+3.
- Vga_Req and Blit_Req asserted in the same cycle -> VGA acked first; Blitter granted in the next IDLE and acked 4 cycles after Vga_Ack.
- Nios_Flip pulsed for 3 cycles while Blit_Busy=1, Blit_Busy dropped, then Vsync rising -> Flip_Pending high throughout, then Front_Sel 0->1, one-cycle Flip_Done, Flip_Pending=0.
- Vsync edge during a Blitter ACCESS while in F_WAIT_VS -> swap deferred to the first arbiter IDLE; the in-flight access keeps its original buffer bit.
- With DBUF_STARVE_GUARD_EN and Vga_Req held high continuously with Blit_Req high -> Blitter granted after 4 consecutive VGA wins.
